// File: rtl/if_fetch_pkg.sv
// Shared widths, stall encodings and FSM state encoding for the instruction-fetch stage.
package if_fetch_pkg;
    localparam int StallBus    = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {
        IF_BOOT    = 2'd0,
        IF_RUN     = 2'd1,
        IF_HOLD    = 2'd2,
        IF_HOLD_BR = 2'd3
    } if_state_e;
endpackage

// File: rtl/if_fetch_br_pend_latch.sv
// Holds a redirect that arrived while the PC stage was stalled; a later capture overwrites it.
module br_pend_latch (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] br_addr,
    output logic        pend_valid,
    output logic [31:0] pend_addr
);
    logic        r_valid;
    logic [31:0] r_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_addr  <= 32'd0;
        end else if (capture) begin
            r_valid <= 1'b1;
            r_addr  <= br_addr;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign pend_valid = r_valid;
    assign pend_addr  = r_addr;
endmodule

// File: rtl/if_fetch.sv
// MIPS IF stage: PC register, synchronous instruction SRAM address, stall-safe redirects.
// Optional misaligned-fetch detection is built when IF_ADDR_CHECK_EN is defined.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [StallBus-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata
`ifdef IF_ADDR_CHECK_EN
    ,
    output logic                   if_adel
`endif
);
    if_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_ce;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic        w_stop;
    logic        w_pend_valid;
    logic [31:0] w_pend_addr;
    logic [31:0] w_next_pc;
    logic        w_unused_stall;

    assign w_br_e         = br_bus[32];
    assign w_br_addr      = br_bus[31:0];
    assign w_stop         = (stall[0] == Stop);
    assign w_unused_stall = ^stall[StallBus-1:1];

    // Live redirect beats a held one, so the last redirect always wins.
    assign w_next_pc = w_br_e       ? w_br_addr   :
                       w_pend_valid ? w_pend_addr :
                                      r_pc + 32'd4;

    br_pend_latch u_pend (
        .clk        (clk),
        .rst        (rst),
        .capture    (w_stop && w_br_e),
        .clear      (!w_stop),
        .br_addr    (w_br_addr),
        .pend_valid (w_pend_valid),
        .pend_addr  (w_pend_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IF_BOOT;
            r_pc    <= RESET_PC - 32'd4;
            r_ce    <= 1'b0;
        end else begin
            case (r_state)
                IF_BOOT: begin
                    if (!w_stop) begin
                        r_pc    <= w_next_pc;
                        r_ce    <= 1'b1;
                        r_state <= IF_RUN;
                    end
                end
                IF_RUN, IF_HOLD: begin
                    if (!w_stop) begin
                        r_pc    <= w_next_pc;
                        r_ce    <= 1'b1;
                        r_state <= IF_RUN;
                    end else if (w_br_e) begin
                        r_state <= IF_HOLD_BR;
                    end else begin
                        r_state <= IF_HOLD;
                    end
                end
                IF_HOLD_BR: begin
                    if (!w_stop) begin
                        r_pc    <= w_next_pc;
                        r_ce    <= 1'b1;
                        r_state <= IF_RUN;
                    end
                end
                default: r_state <= IF_BOOT;
            endcase
        end
    end

    assign if_to_id_bus    = {r_ce, r_pc};
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_wdata = 32'b0;

`ifdef IF_ADDR_CHECK_EN
    // Misaligned PC still travels down the bus so ID can raise AdEL; only the SRAM read is blocked.
    assign if_adel      = r_ce && (r_pc[1:0] != 2'b00);
    assign inst_sram_en = r_ce && !if_adel;
`else
    assign inst_sram_en = r_ce;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: expected PC/ce per cycle queued with the stimulus, checked after each edge.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        adel_obs;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        ce;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
`ifdef IF_ADDR_CHECK_EN
        ,
        .if_adel         (adel_obs)
`endif
    );

`ifndef IF_ADDR_CHECK_EN
    assign adel_obs = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue what the stage must show after the edge, then check it.
    task automatic step(input logic r, input logic [5:0] s, input logic be,
                        input logic [31:0] ba, input logic [31:0] ep, input logic ec,
                        input string tag);
        exp_t e;
        logic mis, exp_en, exp_adel;
        rst    = r;
        stall  = s;
        br_bus = {be, ba};
        sb.push_back('{tag, ep, ec});
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        mis = (e.pc[1:0] != 2'b00);
`ifdef IF_ADDR_CHECK_EN
        exp_adel = e.ce && mis;
`else
        exp_adel = 1'b0;
`endif
        exp_en = e.ce && !exp_adel;
        chk({e.tag, ".addr"}, inst_sram_addr, e.pc);
        chk({e.tag, ".bus_pc"}, if_to_id_bus[31:0], e.pc);
        chk({e.tag, ".bus_ce"}, {31'd0, if_to_id_bus[32]}, {31'd0, e.ce});
        chk({e.tag, ".en"}, {31'd0, inst_sram_en}, {31'd0, exp_en});
        chk({e.tag, ".adel"}, {31'd0, adel_obs}, {31'd0, exp_adel});
        chk({e.tag, ".wen"}, {28'd0, inst_sram_wen}, 32'd0);
        chk({e.tag, ".wdata"}, inst_sram_wdata, 32'd0);
    endtask

    localparam logic [5:0] GO = 6'b000000;
    localparam logic [5:0] ST = 6'b000011;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held for three edges
        step(0, GO, 0, 32'h0, 32'hBFBF_FFFC, 0, "rst0");
        step(0, GO, 0, 32'h0, 32'hBFBF_FFFC, 0, "rst1");
        step(0, GO, 0, 32'h0, 32'hBFBF_FFFC, 0, "rst2");
        // release: one BOOT cycle (checked above), then sequential fetch
        step(1, GO, 0, 32'h0, 32'hBFC0_0000, 1, "boot0");
        step(1, GO, 0, 32'h0, 32'hBFC0_0004, 1, "seq4");
        step(1, GO, 0, 32'h0, 32'hBFC0_0008, 1, "seq8");
        // branch from 0008
        step(1, GO, 1, 32'hBFC0_0100, 32'hBFC0_0100, 1, "br100");
        step(1, GO, 0, 32'h0, 32'hBFC0_0104, 1, "br104");
        step(1, GO, 1, 32'hBFC0_0010, 32'hBFC0_0010, 1, "br010");
        // plain stall hold
        step(1, ST, 0, 32'h0, 32'hBFC0_0010, 1, "hold_a");
        step(1, ST, 0, 32'h0, 32'hBFC0_0010, 1, "hold_b");
        step(1, GO, 0, 32'h0, 32'hBFC0_0014, 1, "hold_rel");
        // redirect on first stall cycle, then br_e drops
        step(1, ST, 1, 32'hBFC0_0200, 32'hBFC0_0014, 1, "hbr_a");
        step(1, ST, 0, 32'h0, 32'hBFC0_0014, 1, "hbr_b");
        step(1, GO, 0, 32'h0, 32'hBFC0_0200, 1, "hbr_rel");
        step(1, GO, 0, 32'h0, 32'hBFC0_0204, 1, "hbr_204");
        // redirect arriving mid-stall (HOLD -> HOLD_BR)
        step(1, ST, 0, 32'h0, 32'hBFC0_0204, 1, "mid_a");
        step(1, ST, 1, 32'hBFC0_0300, 32'hBFC0_0204, 1, "mid_b");
        step(1, ST, 0, 32'h0, 32'hBFC0_0204, 1, "mid_c");
        step(1, GO, 0, 32'h0, 32'hBFC0_0300, 1, "mid_rel");
        // last redirect wins
        step(1, ST, 1, 32'hBFC0_0400, 32'hBFC0_0300, 1, "lw_a");
        step(1, ST, 1, 32'hBFC0_0500, 32'hBFC0_0300, 1, "lw_b");
        step(1, GO, 0, 32'h0, 32'hBFC0_0500, 1, "lw_rel");
        // live br_e at release beats pending
        step(1, ST, 1, 32'hBFC0_0600, 32'hBFC0_0500, 1, "live_a");
        step(1, GO, 1, 32'hBFC0_0700, 32'hBFC0_0700, 1, "live_rel");
        step(1, GO, 0, 32'h0, 32'hBFC0_0704, 1, "live_704");
        // reset while a redirect is pending
        step(1, ST, 1, 32'hBFC0_0200, 32'hBFC0_0704, 1, "rhb_a");
        step(0, ST, 0, 32'h0, 32'hBFBF_FFFC, 0, "rhb_rst");
        step(1, ST, 0, 32'h0, 32'hBFBF_FFFC, 0, "boot_stall");
        step(1, GO, 0, 32'h0, 32'hBFC0_0000, 1, "rhb_boot");
        step(1, GO, 0, 32'h0, 32'hBFC0_0004, 1, "rhb_seq");
        // 32-bit wrap of pc+4
        step(1, GO, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, "wrap_a");
        step(1, GO, 0, 32'h0, 32'h0000_0000, 1, "wrap_b");
        // misaligned target, held under stall, then realigned
        step(1, GO, 1, 32'hBFC0_0102, 32'hBFC0_0102, 1, "mis_a");
        step(1, ST, 0, 32'h0, 32'hBFC0_0102, 1, "mis_hold");
        step(1, GO, 1, 32'hBFC0_0000, 32'hBFC0_0000, 1, "mis_fix");
        step(1, GO, 0, 32'h0, 32'hBFC0_0004, 1, "mis_seq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
